// File: rtl/key_detector.sv
// key_detector: debounces a single keypad key across repeated visits of its
// column by the scanner and reports it as a registered key code with a
// one-clock valid strobe and a held flag.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   n_reset    asynchronous active-low reset
//   pulse_out  scan tick, one clk wide; columnas advances on the same edge
//   columnas   one-hot column drive from the scanner
//   filas      asynchronous row lines, active-high
//   key_code   row*4 + col of the last accepted key
//   key_valid  one-clk pulse when a press is accepted
//   key_held   high from press acceptance until release acceptance
module key_detector #(
  parameter int unsigned PRESS_SCANS   = 4,
  parameter int unsigned RELEASE_SCANS = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       pulse_out,
  input  logic [3:0] columnas,
  input  logic [3:0] filas,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned LINE_W = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, rcnt, rcnt_n, cnt_inc, rcnt_inc;
  logic [IDX_W-1:0]   cand_col, cand_col_n, cand_row, cand_row_n;
  logic [IDX_W-1:0]   col_idx, row_idx;
  logic [LINE_W-1:0]  rows_m, rows_s;
  logic [3:0]         key_code_n;
  logic               key_valid_n, key_held_n;
  logic               sample, hit;

  // Two-flop synchronizer on the asynchronous row lines
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rows_m <= '0;
      rows_s <= '0;
    end else begin
      rows_m <= filas;
      rows_s <= rows_m;
    end
  end

  // Index of the driven column and of the active row (valid only when one-hot)
  always_comb begin
    col_idx = '0;
    row_idx = '0;
    for (int i = 0; i < LINE_W; i++) begin
      if (columnas[i]) col_idx = IDX_W'(i);
      if (rows_s[i])   row_idx = IDX_W'(i);
    end
  end

  // Non-one-hot column drive means the tick carries no usable sample
  assign sample   = pulse_out & $onehot(columnas);
  assign hit      = $onehot(rows_s);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign rcnt_inc = rcnt + CNT_W'(1);

  // Next-state and next-output logic, evaluated only at samples
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rcnt_n      = rcnt;
    cand_col_n  = cand_col;
    cand_row_n  = cand_row;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    key_held_n  = key_held;

    if (sample) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            cand_col_n = col_idx;
            cand_row_n = row_idx;
            if (PRESS_SCANS == 1) begin
              state_n     = PRESSED;
              cnt_n       = '0;
              rcnt_n      = '0;
              key_code_n  = {row_idx, col_idx};
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
              cnt_n   = CNT_W'(1);
            end
          end
        end

        DEBOUNCE: begin
          if (col_idx == cand_col) begin
            if (hit && row_idx == cand_row) begin
              if (cnt_inc == CNT_W'(PRESS_SCANS)) begin
                state_n     = PRESSED;
                cnt_n       = '0;
                rcnt_n      = '0;
                key_code_n  = {cand_row, cand_col};
                key_valid_n = 1'b1;
                key_held_n  = 1'b1;
              end else begin
                cnt_n = cnt_inc;
              end
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end
        end

        PRESSED: begin
          // Only the held key's own row matters; other keys are locked out
          if (col_idx == cand_col) begin
            if (!rows_s[cand_row]) begin
              if (rcnt_inc == CNT_W'(RELEASE_SCANS)) begin
                state_n    = IDLE;
                rcnt_n     = '0;
                key_held_n = 1'b0;
              end else begin
                rcnt_n = rcnt_inc;
              end
            end else begin
              rcnt_n = '0;
            end
          end
        end

        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          rcnt_n  = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      cand_col  <= '0;
      cand_row  <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      cand_col  <= cand_col_n;
      cand_row  <= cand_row_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

endmodule

// File: tb/tb_key_detector.sv
// Directed bench for key_detector: models the column scanner, drives key
// patterns per column visit and checks against hand-computed expectations.
module tb_key_detector;

  logic       clk;
  logic       n_reset;
  logic       pulse_out;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int n_checks;
  int n_pass;
  int vcnt;

  key_detector #(
    .PRESS_SCANS  (4),
    .RELEASE_SCANS(2)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .pulse_out(pulse_out),
    .columnas (columnas),
    .filas    (filas),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One scanner tick: hold column and rows stable, then pulse for one clk
  task automatic tick(input logic [3:0] cols, input logic [3:0] rows);
    @(negedge clk);
    columnas  = cols;
    filas     = rows;
    pulse_out = 1'b0;
    repeat (3) @(negedge clk);
    pulse_out = 1'b1;
    @(negedge clk);
    pulse_out = 1'b0;
    if (key_valid) vcnt++;
  endtask

  // One full scan: visit columns 0..3 with the given row pattern on each
  task automatic round(input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [3:0] r3);
    tick(4'b0001, r0);
    tick(4'b0010, r1);
    tick(4'b0100, r2);
    tick(4'b1000, r3);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    vcnt      = 0;
    n_reset   = 1'b0;
    pulse_out = 1'b0;
    columnas  = 4'b0000;
    filas     = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    n_reset = 1'b1;

    // Clean press: row 2 at col 2 -> code 0xA on the 4th visit
    repeat (3) round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check("press_early_valid", 32'(vcnt), 32'd0);
    check("press_early_held", 32'(key_held), 32'h0);
    round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check("press_valid", 32'(vcnt), 32'd1);
    check("press_code", 32'(key_code), 32'hA);
    check("press_held", 32'(key_held), 32'h1);
    repeat (2) round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check("press_one_pulse", 32'(vcnt), 32'd1);

    // Lockout: row 0 at col 1 while 0xA is held
    repeat (4) round(4'b0000, 4'b0001, 4'b0100, 4'b0000);
    check("lock_valid", 32'(vcnt), 32'd1);
    check("lock_code", 32'(key_code), 32'hA);
    check("lock_held", 32'(key_held), 32'h1);

    // Release: two empty visits of col 2
    round(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("rel_one_empty", 32'(key_held), 32'h1);
    round(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("rel_held", 32'(key_held), 32'h0);
    check("rel_code", 32'(key_code), 32'hA);
    check("rel_valid", 32'(vcnt), 32'd1);

    // Ghost: two rows at col 0 never produce a key
    vcnt = 0;
    repeat (8) round(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    check("ghost_valid", 32'(vcnt), 32'd0);
    check("ghost_held", 32'(key_held), 32'h0);

    // Bounce: row 1 at col 3 on visits 1,2, gap on 3, then 4..7
    repeat (2) round(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    round(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) round(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    check("bounce_early_valid", 32'(vcnt), 32'd0);
    round(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    check("bounce_valid", 32'(vcnt), 32'd1);
    check("bounce_code", 32'(key_code), 32'h7);
    check("bounce_held", 32'(key_held), 32'h1);
    repeat (2) round(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("bounce_release", 32'(key_held), 32'h0);

    // Non-one-hot ticks during debounce of row 3 col 0 are ignored
    vcnt = 0;
    repeat (2) round(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0110, 4'b0000);
    tick(4'b0000, 4'b1000);
    round(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    check("nonhot_early_valid", 32'(vcnt), 32'd0);
    round(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    check("nonhot_valid", 32'(vcnt), 32'd1);
    check("nonhot_code", 32'(key_code), 32'hC);
    repeat (2) round(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("nonhot_release", 32'(key_held), 32'h0);

    // Reset mid-debounce discards progress and clears outputs at once
    vcnt = 0;
    repeat (2) round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_held", 32'(key_held), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check("midrst_fresh_early", 32'(vcnt), 32'd0);
    round(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check("midrst_fresh_valid", 32'(vcnt), 32'd1);
    check("midrst_fresh_code", 32'(key_code), 32'hA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
